// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: widths, ALU op codes, operand-B select
// encodings and control-bit positions.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int RIDX = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_OR   = 4'b0110,
        ALU_SRCB = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        BSRC_BUSB = 2'b00,
        BSRC_FOUR = 2'b01,
        BSRC_IMM  = 2'b10
    } bsrc_e;

    localparam int CTRL_REGWR    = 3;
    localparam int CTRL_MEMWR    = 2;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_BRANCH   = 0;

    // A later stage supplies the value only when it writes a non-x0 register that matches
    function automatic logic wr_hit(logic wr_en, logic [RIDX-1:0] wr_rd, logic [RIDX-1:0] rs);
        return wr_en && (wr_rd != '0) && (wr_rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode, the ID/EX register, the later pipeline stages and the ALU.
interface id_ex_stage_if;
    import cpu_pkg::*;

    logic            id_valid;
    logic [XLEN-1:0] id_PC;
    logic [3:0]      id_ALUctr;
    logic            id_ALUASrc;
    logic [1:0]      id_ALUBSrc;
    logic [XLEN-1:0] id_busA;
    logic [XLEN-1:0] id_busB;
    logic [XLEN-1:0] id_imm;
    logic [RIDX-1:0] id_rs1;
    logic [RIDX-1:0] id_rs2;
    logic [RIDX-1:0] id_rd;
    logic [3:0]      id_ctrl;
    logic            flush;

    logic            mem_RegWr;
    logic [RIDX-1:0] mem_rd;
    logic [XLEN-1:0] mem_ALUout;
    logic            wb_RegWr;
    logic [RIDX-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            ex_valid;
    logic [XLEN-1:0] ex_PC;
    logic [XLEN-1:0] ex_imm;
    logic [3:0]      ex_ALUctr;
    logic            ex_ALUASrc;
    logic [1:0]      ex_ALUBSrc;
    logic [XLEN-1:0] ex_busA;
    logic [XLEN-1:0] ex_busB;
    logic [RIDX-1:0] ex_rd;
    logic [3:0]      ex_ctrl;
    logic            stall_id;

    modport master (
        output id_valid, id_PC, id_ALUctr, id_ALUASrc, id_ALUBSrc, id_busA, id_busB,
               id_imm, id_rs1, id_rs2, id_rd, id_ctrl, flush,
               mem_RegWr, mem_rd, mem_ALUout, wb_RegWr, wb_rd, wb_data,
        input  ex_valid, ex_PC, ex_imm, ex_ALUctr, ex_ALUASrc, ex_ALUBSrc,
               ex_busA, ex_busB, ex_rd, ex_ctrl, stall_id
    );

    modport slave (
        input  id_valid, id_PC, id_ALUctr, id_ALUASrc, id_ALUBSrc, id_busA, id_busB,
               id_imm, id_rs1, id_rs2, id_rd, id_ctrl, flush,
               mem_RegWr, mem_rd, mem_ALUout, wb_RegWr, wb_rd, wb_data,
        output ex_valid, ex_PC, ex_imm, ex_ALUctr, ex_ALUASrc, ex_ALUBSrc,
               ex_busA, ex_busB, ex_rd, ex_ctrl, stall_id
    );

endinterface

// File: rtl/fwd_unit.sv
// Operand bypass for one ALU source: EX/MEM result beats MEM/WB, x0 is never bypassed.
module fwd_unit
    import cpu_pkg::*;
(
    input  logic [RIDX-1:0] rs_i,
    input  logic [XLEN-1:0] val_i,
    input  logic            mem_regwr_i,
    input  logic [RIDX-1:0] mem_rd_i,
    input  logic [XLEN-1:0] mem_data_i,
    input  logic            wb_regwr_i,
    input  logic [RIDX-1:0] wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic [XLEN-1:0] val_o
);

    always_comb begin
        val_o = val_i;
        if (wr_hit(mem_regwr_i, mem_rd_i, rs_i)) begin
            val_o = mem_data_i;
        end else if (wr_hit(wb_regwr_i, wb_rd_i, rs_i)) begin
            val_o = wb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash and
// operand forwarding onto the ALU input buses.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);

    logic            valid_q,  valid_d;
    logic [XLEN-1:0] pc_q,     pc_d;
    logic [XLEN-1:0] imm_q,    imm_d;
    logic [3:0]      aluctr_q, aluctr_d;
    logic            asrc_q,   asrc_d;
    logic [1:0]      bsrc_q,   bsrc_d;
    logic [XLEN-1:0] busa_q,   busa_d;
    logic [XLEN-1:0] busb_q,   busb_d;
    logic [RIDX-1:0] rs1_q,    rs1_d;
    logic [RIDX-1:0] rs2_q,    rs2_d;
    logic [RIDX-1:0] rd_q,     rd_d;
    logic [3:0]      ctrl_q,   ctrl_d;

    logic stall;

    // Load in EX whose result the instruction in ID needs; a flush makes it moot
    always_comb begin
        stall = bus.id_valid && valid_q && ctrl_q[CTRL_MEMTOREG] && (rd_q != '0) &&
                ((rd_q == bus.id_rs1) || (rd_q == bus.id_rs2)) && !bus.flush;
    end

    always_comb begin
        valid_d  = 1'b0;
        pc_d     = '0;
        imm_d    = '0;
        aluctr_d = ALU_ADD;
        asrc_d   = 1'b0;
        bsrc_d   = BSRC_BUSB;
        busa_d   = '0;
        busb_d   = '0;
        rs1_d    = '0;
        rs2_d    = '0;
        rd_d     = '0;
        ctrl_d   = '0;
        if (!bus.flush && !stall) begin
            valid_d = bus.id_valid;
            pc_d    = bus.id_PC;
            imm_d   = bus.id_imm;
            rs1_d   = bus.id_rs1;
            rs2_d   = bus.id_rs2;
            // Register file write lands this same edge, so pick it up directly
            busa_d  = wr_hit(bus.wb_RegWr, bus.wb_rd, bus.id_rs1) ? bus.wb_data : bus.id_busA;
            busb_d  = wr_hit(bus.wb_RegWr, bus.wb_rd, bus.id_rs2) ? bus.wb_data : bus.id_busB;
            if (bus.id_valid) begin
                aluctr_d = bus.id_ALUctr;
                asrc_d   = bus.id_ALUASrc;
                bsrc_d   = bus.id_ALUBSrc;
                rd_d     = bus.id_rd;
                ctrl_d   = bus.id_ctrl;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            imm_q    <= '0;
            aluctr_q <= '0;
            asrc_q   <= 1'b0;
            bsrc_q   <= '0;
            busa_q   <= '0;
            busb_q   <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            ctrl_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            imm_q    <= imm_d;
            aluctr_q <= aluctr_d;
            asrc_q   <= asrc_d;
            bsrc_q   <= bsrc_d;
            busa_q   <= busa_d;
            busb_q   <= busb_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            ctrl_q   <= ctrl_d;
        end
    end

    fwd_unit u_fwd_a (
        .rs_i        (rs1_q),
        .val_i       (busa_q),
        .mem_regwr_i (bus.mem_RegWr),
        .mem_rd_i    (bus.mem_rd),
        .mem_data_i  (bus.mem_ALUout),
        .wb_regwr_i  (bus.wb_RegWr),
        .wb_rd_i     (bus.wb_rd),
        .wb_data_i   (bus.wb_data),
        .val_o       (bus.ex_busA)
    );

    fwd_unit u_fwd_b (
        .rs_i        (rs2_q),
        .val_i       (busb_q),
        .mem_regwr_i (bus.mem_RegWr),
        .mem_rd_i    (bus.mem_rd),
        .mem_data_i  (bus.mem_ALUout),
        .wb_regwr_i  (bus.wb_RegWr),
        .wb_rd_i     (bus.wb_rd),
        .wb_data_i   (bus.wb_data),
        .val_o       (bus.ex_busB)
    );

    assign bus.ex_valid   = valid_q;
    assign bus.ex_PC      = pc_q;
    assign bus.ex_imm     = imm_q;
    assign bus.ex_ALUctr  = aluctr_q;
    assign bus.ex_ALUASrc = asrc_q;
    assign bus.ex_ALUBSrc = bsrc_q;
    assign bus.ex_rd      = rd_q;
    assign bus.ex_ctrl    = ctrl_q;
    assign bus.stall_id   = stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, load-use bubble, flush, forwarding and write-through.
module tb_id_ex_stage;
    import cpu_pkg::*;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    id_ex_stage_if bus ();

    id_ex_stage u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [3:0] op,
                          input logic asrc, input logic [1:0] bsrc,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [3:0] ctrl);
        bus.id_valid   = v;
        bus.id_PC      = pc;
        bus.id_ALUctr  = op;
        bus.id_ALUASrc = asrc;
        bus.id_ALUBSrc = bsrc;
        bus.id_busA    = a;
        bus.id_busB    = b;
        bus.id_imm     = imm;
        bus.id_rs1     = rs1;
        bus.id_rs2     = rs2;
        bus.id_rd      = rd;
        bus.id_ctrl    = ctrl;
    endtask

    task automatic set_fwd(input logic mw, input logic [4:0] mrd, input logic [31:0] mdat,
                           input logic ww, input logic [4:0] wrd, input logic [31:0] wdat);
        bus.mem_RegWr  = mw;
        bus.mem_rd     = mrd;
        bus.mem_ALUout = mdat;
        bus.wb_RegWr   = ww;
        bus.wb_rd      = wrd;
        bus.wb_data    = wdat;
    endtask

    initial begin
        rst_n = 1'b1;
        bus.flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_valid",  32'(bus.ex_valid), 0);
        check_val("rst_ctrl",   32'(bus.ex_ctrl), 0);
        check_val("rst_aluctr", 32'(bus.ex_ALUctr), 0);
        check_val("rst_rd",     32'(bus.ex_rd), 0);
        check_val("rst_busA",   bus.ex_busA, 0);
        check_val("rst_busB",   bus.ex_busB, 0);
        check_val("rst_stall",  32'(bus.stall_id), 0);

        // Plain capture
        set_id(1, 32'h100, ALU_ADD, 0, BSRC_BUSB, 5, 7, 0, 1, 2, 3, 4'b1000);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_val("cap_pc",    bus.ex_PC, 32'h100);
        check_val("cap_busA",  bus.ex_busA, 5);
        check_val("cap_busB",  bus.ex_busB, 7);
        check_val("cap_valid", 32'(bus.ex_valid), 1);
        check_val("cap_rd",    32'(bus.ex_rd), 3);
        check_val("cap_ctrl",  32'(bus.ex_ctrl), 32'h8);

        // Load into EX, then dependent instruction in ID
        set_id(1, 32'h104, ALU_ADD, 0, BSRC_IMM, 9, 0, 8, 1, 0, 5, 4'b1010);
        step();
        check_val("ld_bsrc", 32'(bus.ex_ALUBSrc), 2);
        check_val("ld_imm",  bus.ex_imm, 8);
        set_id(1, 32'h108, ALU_SLT, 1, BSRC_FOUR, 3, 4, 0, 5, 2, 6, 4'b1000);
        #1;
        check_val("lu_stall", 32'(bus.stall_id), 1);
        step();
        check_val("lu_bub_valid", 32'(bus.ex_valid), 0);
        check_val("lu_bub_ctrl",  32'(bus.ex_ctrl), 0);
        check_val("lu_bub_pc",    bus.ex_PC, 0);
        check_val("lu_clear",     32'(bus.stall_id), 0);
        step();
        check_val("lu_cap_valid", 32'(bus.ex_valid), 1);
        check_val("lu_cap_pc",    bus.ex_PC, 32'h108);
        check_val("lu_cap_rd",    32'(bus.ex_rd), 6);
        check_val("lu_cap_op",    32'(bus.ex_ALUctr), 32'(ALU_SLT));
        check_val("lu_cap_asrc",  32'(bus.ex_ALUASrc), 1);
        check_val("lu_cap_bsrc",  32'(bus.ex_ALUBSrc), 1);
        check_val("lu_cap_stall", 32'(bus.stall_id), 0);

        // Forward priority and x0 guard
        set_id(1, 32'h10C, ALU_OR, 0, BSRC_BUSB, 32'h11, 32'h22, 0, 4, 0, 8, 4'b1000);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(1, 4, 32'hAA, 1, 4, 32'hBB);
        #1;
        check_val("fwd_mem", bus.ex_busA, 32'hAA);
        bus.mem_RegWr = 1'b0;
        #1;
        check_val("fwd_wb", bus.ex_busA, 32'hBB);
        bus.wb_RegWr = 1'b0;
        #1;
        check_val("fwd_none", bus.ex_busA, 32'h11);
        set_fwd(1, 0, 32'hFFFF, 1, 0, 32'h33);
        #1;
        check_val("x0_busB", bus.ex_busB, 32'h22);
        set_fwd(0, 0, 0, 0, 0, 0);

        // Flush beats a load-use stall
        set_id(1, 32'h110, ALU_ADD, 0, BSRC_IMM, 0, 0, 4, 1, 0, 7, 4'b1010);
        step();
        set_id(1, 32'h114, ALU_SUB, 0, BSRC_BUSB, 1, 2, 0, 3, 7, 9, 4'b1000);
        #1;
        check_val("fl_pre_stall", 32'(bus.stall_id), 1);
        bus.flush = 1'b1;
        #1;
        check_val("fl_stall", 32'(bus.stall_id), 0);
        step();
        bus.flush = 1'b0;
        check_val("fl_valid", 32'(bus.ex_valid), 0);
        check_val("fl_ctrl",  32'(bus.ex_ctrl), 0);
        check_val("fl_rd",    32'(bus.ex_rd), 0);

        // Write-through on capture
        set_id(1, 32'h118, ALU_ADD, 0, BSRC_BUSB, 1, 2, 0, 6, 6, 10, 4'b1000);
        set_fwd(0, 0, 0, 1, 6, 32'h55);
        step();
        bus.wb_RegWr = 1'b0;
        #1;
        check_val("wt_busA", bus.ex_busA, 32'h55);
        check_val("wt_busB", bus.ex_busB, 32'h55);

        // Non-valid ID capture zeroes controls
        set_id(0, 32'h11C, ALU_SUB, 1, BSRC_IMM, 1, 2, 3, 1, 2, 9, 4'b1000);
        step();
        check_val("nv_valid", 32'(bus.ex_valid), 0);
        check_val("nv_ctrl",  32'(bus.ex_ctrl), 0);
        check_val("nv_rd",    32'(bus.ex_rd), 0);
        check_val("nv_op",    32'(bus.ex_ALUctr), 0);

        // Reset during a stall
        set_id(1, 32'h120, ALU_ADD, 0, BSRC_IMM, 0, 0, 0, 1, 0, 12, 4'b1010);
        step();
        set_id(1, 32'h124, ALU_ADD, 0, BSRC_BUSB, 0, 0, 0, 12, 0, 13, 4'b1000);
        #1;
        check_val("rs_pre_stall", 32'(bus.stall_id), 1);
        rst_n = 1'b0;
        #1;
        check_val("rs_stall", 32'(bus.stall_id), 0);
        check_val("rs_valid", 32'(bus.ex_valid), 0);
        check_val("rs_pc",    bus.ex_PC, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_val("rs_cap_pc", bus.ex_PC, 32'h124);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
